bcd_serial_adder: RTL and testbench

//  Multi-digit packed-BCD adder. Each job adds two NDIG-digit operands

---
 rtl/bcd_serial_adder_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 29 ++
 rtl/bcd_serial_adder.sv | 168 ++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder:
// FSM encoding, decimal constants and a digit-validity helper.
package bcd_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] DEC_MAX = 4'd9;
   localparam logic [3:0] DEC_ADJ = 4'd6;

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > DEC_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal-carry correction.
// Invalid digits go through the same correction rule and are flagged on bad.
module bcd_digit_add
   import bcd_serial_adder_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       bad
);

   logic [4:0] z_s;

   // binary sum, then +6 (mod 16) whenever the sum leaves the decimal range
   always_comb begin
      z_s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      if (z_s > {1'b0, DEC_MAX}) begin
         s  = z_s[3:0] + DEC_ADJ;
         co = 1'b1;
      end else begin
         s  = z_s[3:0];
         co = 1'b0;
      end
      bad = digit_bad(a) | digit_bad(b);
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least significant first,
// sharing a single bcd_digit_add through idx-selected digit muxes.
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   input  logic              cin,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] sum,
   output logic              cout,
   output logic              err
);

   localparam int W  = 4 * NDIG;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    work_q, work_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [W-1:0]    a_sh_s, b_sh_s;
   logic [3:0]      dig_a_s, dig_b_s, dig_s_s;
   logic            dig_co_s, dig_bad_s;

   // select the current digit of each latched operand
   always_comb begin
      a_sh_s  = a_q >> {idx_q, 2'b00};
      b_sh_s  = b_q >> {idx_q, 2'b00};
      dig_a_s = a_sh_s[3:0];
      dig_b_s = b_sh_s[3:0];
   end

   bcd_digit_add u_digit (
      .a   (dig_a_s),
      .b   (dig_b_s),
      .ci  (carry_q),
      .s   (dig_s_s),
      .co  (dig_co_s),
      .bad (dig_bad_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
            else       state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (idx_q == LAST) state_d = ST_DONE;
            else               state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_d = ST_RUN;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs, registered from the next state
   always_comb begin
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // datapath next state: latch on accepted start, one digit per RUN edge
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               work_d  = '0;
               err_d   = 1'b0;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q;
            end
         end
         ST_RUN: begin
            work_d[{idx_q, 2'b00} +: 4] = dig_s_s;
            carry_d = dig_co_s;
            err_d   = err_q | dig_bad_s;
            // the final digit publishes the whole result at once
            if (idx_q == LAST) begin
               sum_d  = work_d;
               cout_d = dig_co_s;
               idx_d  = idx_q;
            end else begin
               idx_d  = idx_q + IW'(1);
            end
         end
         default: begin
            idx_d = '0;
         end
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (NDIG=4): directed jobs push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_bcd_serial_adder;

   localparam int NDIG = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        err;

   typedef struct {
      int          id;
      logic [15:0] sum;
      logic        cout;
      logic        err;
      logic        chk_sum;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   bcd_serial_adder #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s job=%0d actual=%0h expected=%0h", name, id, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding job
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done cyc=%0d actual=1 expected=0", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk_sum) begin
               check("sum", e.id, {16'h0000, sum}, {16'h0000, e.sum});
               check("cout", e.id, {31'd0, cout}, {31'd0, e.cout});
            end
            check("err", e.id, {31'd0, err}, {31'd0, e.err});
            check("latency", e.id, cyc, e.cyc);
            check("busy_at_done", e.id, {31'd0, busy}, 32'd0);
         end
      end
   end

   // caller is at a negedge; start is sampled on exactly one posedge
   task automatic start_job(input int id, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tcin, input logic push, input logic [15:0] es,
                            input logic ec, input logic ee, input logic chk);
      exp_t e;
      a     = ta;
      b     = tb_;
      cin   = tcin;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         e.id = id; e.sum = es; e.cout = ec; e.err = ee; e.chk_sum = chk;
         e.cyc = cyc + NDIG;
         sb_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input int id);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout job=%0d actual=pending expected=done", id);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 0, {31'd0, busy}, 32'd0);
      check("rst_done", 0, {31'd0, done}, 32'd0);
      check("rst_sum",  0, {16'h0000, sum}, 32'd0);
      check("rst_cout", 0, {31'd0, cout}, 32'd0);
      check("rst_err",  0, {31'd0, err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      start_job(1, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b1);
      drain(1);
      start_job(2, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain(2);
      start_job(3, 16'h9999, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
      drain(3);
      start_job(4, 16'h0500, 16'h0500, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1);
      drain(4);

      // abandoned job: reset mid-run, outputs clear immediately, no done
      start_job(5, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", 5, {31'd0, busy}, 32'd0);
      check("midrst_done", 5, {31'd0, done}, 32'd0);
      check("midrst_sum",  5, {16'h0000, sum}, 32'd0);
      check("midrst_cout", 5, {31'd0, cout}, 32'd0);
      check("midrst_err",  5, {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      start_job(6, 16'h4321, 16'h0000, 1'b1, 1'b1, 16'h4322, 1'b0, 1'b0, 1'b1);
      drain(6);

      // start while busy is ignored; start during DONE chains with no gap
      start_job(7, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b1);
      a = 16'h0000; b = 16'h0000; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 7, {31'd0, done}, 32'd1);
      start_job(8, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain(8);

      // invalid digit flags err; sum is not checked for that job
      start_job(9, 16'h00A0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
      drain(9);
      start_job(10, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
      drain(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
